// File: rtl/io_halt_seq.sv
// io_halt_seq: stall/halt sequencer for the SIMPLE 16-bit pipeline.
// Freezes PC/IF/ID while an Input or Output instruction completes its
// external handshake, drains older instructions on Halt, and holds the
// core stopped after reset until a run request arrives.
module io_halt_seq #(
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        id_valid,
    input  logic        id_input,
    input  logic        id_output,
    input  logic        id_halt,
    input  logic [15:0] id_out_data,
    input  logic [15:0] ext_in_data,
    input  logic        ext_in_valid,
    output logic        ext_in_ready,
    output logic [15:0] ext_out_data,
    output logic        ext_out_valid,
    input  logic        ext_out_ready,
    output logic [15:0] in_data,
    output logic        stall,
    output logic        halted
);

    typedef enum logic [2:0] {
        ST_HALT     = 3'd0,
        ST_RUN      = 3'd1,
        ST_IN_WAIT  = 3'd2,
        ST_OUT_WAIT = 3'd3,
        ST_RELEASE  = 3'd4,
        ST_DRAIN    = 3'd5
    } state_t;

    // Counter reload: the last DRAIN cycle is the one that sees zero.
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  drain_cnt_r;
    logic [3:0]  drain_cnt_s;
    logic [15:0] out_data_r;
    logic [15:0] in_data_r;
    logic        in_ready_r;
    logic        out_valid_r;
    logic        halted_r;

    logic        special_s;
    logic        stall_s;
    logic        out_load_s;
    logic        in_cap_s;

    // Next-state, drain counter and stall decode; halt outranks input outranks output.
    always_comb begin
        state_s     = state_r;
        drain_cnt_s = drain_cnt_r;
        stall_s     = 1'b1;
        special_s   = id_valid & (id_halt | id_input | id_output);
        out_load_s  = 1'b0;
        in_cap_s    = 1'b0;
        case (state_r)
            ST_HALT: begin
                if (run) begin
                    state_s = ST_RELEASE;
                end else begin
                    state_s = ST_HALT;
                end
            end
            ST_RUN: begin
                // Only state where the stall follows the decoder combinationally.
                stall_s = special_s;
                if (special_s) begin
                    if (id_halt) begin
                        state_s     = ST_DRAIN;
                        drain_cnt_s = DRAIN_LOAD;
                    end else if (id_input) begin
                        state_s = ST_IN_WAIT;
                    end else begin
                        state_s    = ST_OUT_WAIT;
                        out_load_s = 1'b1;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_IN_WAIT: begin
                if (ext_in_valid) begin
                    state_s  = ST_RELEASE;
                    in_cap_s = 1'b1;
                end else begin
                    state_s = ST_IN_WAIT;
                end
            end
            ST_OUT_WAIT: begin
                if (ext_out_ready) begin
                    state_s = ST_RELEASE;
                end else begin
                    state_s = ST_OUT_WAIT;
                end
            end
            ST_RELEASE: begin
                // One unstalled cycle lets the held instruction leave ID;
                // its still-visible flags must not retrigger the sequencer.
                stall_s = 1'b0;
                state_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (drain_cnt_r == 4'd0) begin
                    state_s = ST_HALT;
                end else begin
                    state_s     = ST_DRAIN;
                    drain_cnt_s = drain_cnt_r - 4'd1;
                end
            end
            default: begin
                state_s     = ST_HALT;
                drain_cnt_s = 4'd0;
            end
        endcase
    end

    // State, data and handshake registers; handshake/halted flags come from the next state so they are glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_HALT;
            drain_cnt_r <= 4'd0;
            out_data_r  <= 16'h0000;
            in_data_r   <= 16'h0000;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            halted_r    <= 1'b1;
        end else begin
            state_r     <= state_s;
            drain_cnt_r <= drain_cnt_s;
            if (out_load_s) begin
                out_data_r <= id_out_data;
            end
            if (in_cap_s) begin
                in_data_r <= ext_in_data;
            end
            in_ready_r  <= (state_s == ST_IN_WAIT);
            out_valid_r <= (state_s == ST_OUT_WAIT);
            halted_r    <= (state_s == ST_HALT);
        end
    end

    assign stall         = stall_s;
    assign halted        = halted_r;
    assign ext_in_ready  = in_ready_r;
    assign ext_out_valid = out_valid_r;
    assign ext_out_data  = out_data_r;
    assign in_data       = in_data_r;

endmodule

// File: doc/io_halt_seq.md
# io_halt_seq

Pipeline sequencer for the SIMPLE 16-bit pipelined core. It owns the stall line for Input, Output and Halt instructions. It holds the decoding instruction in ID while an external I/O handshake completes, and drains the pipeline on Halt. It also gates start-up after reset. It sits beside the decode stage, consumes the decoder's Input/Output/Halt flags, and drives the PC/IF/ID freeze.

## Interface
Parameters:
- DRAIN_CYCLES, 3, cycles to hold Halt in ID so older instructions retire (range 1–15)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- run  in  1  start/resume request; honoured only in HALT
- id_valid  in  1  ID stage holds a real instruction
- id_input  in  1  decoder Input flag for ID instruction
- id_output  in  1  decoder Output flag for ID instruction
- id_halt  in  1  decoder Halt flag for ID instruction
- id_out_data  in  16  operand value for Output, valid while ID holds it
- ext_in_data  in  16  external input word
- ext_in_valid  in  1  external input word available
- ext_in_ready  out  1  sequencer accepting input
- ext_out_data  out  16  registered output word
- ext_out_valid  out  1  output word presented
- ext_out_ready  in  1  external sink accepts output
- in_data  out  16  last accepted input word, to writeback mux
- stall  out  1  freeze PC, IF/ID register, and bubble into EX
- halted  out  1  core stopped

## Operation
- States: HALT, RUN, IN_WAIT, OUT_WAIT, RELEASE, DRAIN.
- The ID instruction is "special" when id_valid & (id_halt | id_input | id_output).
- Priority when several flags are set: halt > input > output.
- HALT:
  - stall=1, halted=1.
  - run=1 -> RELEASE.
- RUN:
  - stall = special (combinational). No special -> stay in RUN.
  - Halt -> DRAIN; drain counter loads DRAIN_CYCLES-1.
  - Input -> IN_WAIT.
  - Output -> OUT_WAIT; ext_out_data <= id_out_data.
- IN_WAIT:
  - stall=1, ext_in_ready=1.
  - On ext_in_valid: in_data <= ext_in_data, then -> RELEASE.
- OUT_WAIT:
  - stall=1, ext_out_valid=1.
  - ext_out_data stays constant.
  - On ext_out_ready -> RELEASE.
- RELEASE:
  - Lasts one cycle. stall=0 so the held instruction advances.
  - ID flags are ignored this cycle. Always -> RUN.
- DRAIN:
  - stall=1. The counter decrements each cycle.
  - At 0 -> HALT. The Halt instruction stays in ID.
- Resume after Halt: run in HALT -> RELEASE. The Halt advances and execution continues at the next PC.
- in_data holds its value until the next accepted input. It is never cleared except by rst.
- run outside HALT is ignored.
- rst mid-operation: any state -> HALT next edge.
  - The pending handshake is abandoned: ext_in_ready and ext_out_valid drop without completion.
  - The drain counter is cleared.

## Timing
- Reset values: state HALT, stall 1, halted 1, ext_in_ready 0, ext_out_valid 0, ext_out_data 0x0000, in_data 0x0000, drain counter 0.
- Output registers and the handshake:
  - stall in RUN is combinational from the ID flags. All other outputs are decoded from state or registers.
  - ext_out_data, ext_out_valid and ext_in_ready are glitch-free registered/state-decoded.
  - ext_in_ready and ext_out_valid assert the cycle after detection.
- Input instruction, minimum stall: detect cycle + 1 wait cycle (ext_in_valid already high), then RELEASE.
  - The instruction leaves ID 3 edges after entering it.
  - in_data is valid from the RELEASE cycle onward.
- Output handshake:
  - The transfer occurs on the edge where ext_out_valid & ext_out_ready are both high.
  - ext_out_valid drops the next cycle.
  - ext_out_ready high with ext_out_valid low is ignored.
- Halt: detect + DRAIN_CYCLES cycles of DRAIN, then halted=1 the following cycle.
- run and a new special instruction in the same cycle cannot conflict: run only acts in HALT, flags only act in RUN.

## Test plan
- Reset then idle: hold rst 2 cycles -> stall=1, halted=1, all data outputs 0x0000. Pulse run -> one RELEASE cycle with stall=0, then RUN with stall=0.
- Input with immediate data: ID Input, ext_in_valid=1, ext_in_data=0xBEEF.
  - ext_in_ready high exactly 1 cycle; in_data=0xBEEF.
  - stall high 2 cycles, then 0 for RELEASE.
- Output with 4-cycle backpressure: id_out_data=0x1234, ext_out_ready low 4 cycles then high.
  - ext_out_valid high 5 cycles; ext_out_data=0x1234 constant.
  - Single transfer, then RELEASE.
- Halt and resume: ID Halt with DRAIN_CYCLES=3.
  - stall=1 at detect, 3 DRAIN cycles, halted=1.
  - run -> RELEASE, halted=0, back to RUN.
- Priority: id_halt=id_input=id_output=1 -> DRAIN entered; ext_in_ready and ext_out_valid never assert.
- Reset mid-handshake: in OUT_WAIT with ext_out_ready=0, assert rst -> next edge HALT, ext_out_valid=0, ext_out_data=0x0000.
